// File: rtl/uart_reg_master.sv
// uart_reg_master: host-side UART initiator for W/R/B/b register-access commands
module uart_reg_master #(
  parameter int CLK_FREQ   = 27000000,
  parameter int BAUD_RATE  = 115200,
  parameter int RX_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       resetb,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [1:0] cmd_op_i,
  input  logic [7:0] cmd_addr_i,
  input  logic [7:0] cmd_len_i,
  input  logic [7:0] wr_data_i,
  input  logic       wr_valid_i,
  output logic       wr_ready_o,
  output logic [7:0] rd_data_o,
  output logic       rd_valid_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o,
  output logic       uart_tx_o,
  input  logic       uart_rx_i
);
  localparam int BIT_TIMER = CLK_FREQ / BAUD_RATE;
  localparam int TIMEOUT = RX_TIMEOUT * BIT_TIMER;
  localparam int BW = $clog2(BIT_TIMER + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [BW-1:0] BIT_END = BW'(BIT_TIMER - 1);
  localparam logic [BW-1:0] BIT_MID = BW'(BIT_TIMER / 2 - 1);
  localparam logic [TW-1:0] TMO_END = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, SEND_CMD, SEND_ADDR, SEND_LEN, SEND_DATA, RECV} state_t;

  state_t state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [7:0] addr_q, addr_d, len_q, len_d, cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic sent_q, sent_d, done_q, done_d, err_q, err_d;
  logic load, wr_hs, data_ph, tx_last, tx_idle;
  logic [7:0] load_byte, op_byte;

  logic tx_busy_q;
  logic [3:0] tx_bit_q;
  logic [BW-1:0] tx_tmr_q;
  logic [9:0] tx_sh_q;

  logic rx_s1_q, rx_s2_q, rx_prev_q, rx_busy_q;
  logic [3:0] rx_bit_q;
  logic [BW-1:0] rx_tmr_q;
  logic [7:0] rx_sh_q;
  logic rx_smp, rx_stop, rx_ferr;

  // the serializer accepts a new byte during the final clock of a stop bit, so bytes run back to back
  assign tx_last = tx_busy_q && tx_bit_q == 4'd9 && tx_tmr_q == BIT_END;
  assign tx_idle = !tx_busy_q || tx_last;
  assign uart_tx_o = tx_busy_q ? tx_sh_q[0] : 1'b1;

  assign rx_smp = rx_busy_q && rx_tmr_q == (rx_bit_q == 4'd0 ? BIT_MID : BIT_END);
  assign rx_stop = rx_smp && rx_bit_q == 4'd9;
  assign rx_ferr = rx_stop && !rx_s2_q;
  assign rd_valid_o = rx_stop && rx_s2_q && state_q == RECV;
  assign rd_data_o = rx_sh_q;

  // write data may be taken in the last stop-bit clock of addr/len so the first data byte has no gap
  assign data_ph = state_q == SEND_DATA ||
                   (tx_last && !op_q[0] && (state_q == SEND_LEN || (state_q == SEND_ADDR && !op_q[1])));
  assign wr_ready_o = data_ph && tx_idle && !sent_q;
  assign wr_hs = wr_ready_o && wr_valid_i;

  assign op_byte = cmd_op_i[1] ? (cmd_op_i[0] ? 8'h62 : 8'h42) : (cmd_op_i[0] ? 8'h52 : 8'h57);
  assign cmd_ready_o = resetb && state_q == IDLE;
  assign busy_o = state_q != IDLE;
  assign done_o = done_q;
  assign err_o = err_q;

  // transmit shift register: start, 8 data bits LSB first, stop
  always_ff @(posedge clk) begin
    if (!resetb) begin
      tx_busy_q <= 1'b0;
      tx_bit_q <= '0;
      tx_tmr_q <= '0;
      tx_sh_q <= '1;
    end else if (load) begin
      tx_busy_q <= 1'b1;
      tx_bit_q <= '0;
      tx_tmr_q <= '0;
      tx_sh_q <= {1'b1, load_byte, 1'b0};
    end else if (tx_busy_q) begin
      if (tx_tmr_q == BIT_END) begin
        tx_tmr_q <= '0;
        tx_bit_q <= tx_bit_q + 4'd1;
        tx_sh_q <= {1'b1, tx_sh_q[9:1]};
        if (tx_bit_q == 4'd9) tx_busy_q <= 1'b0;
      end else begin
        tx_tmr_q <= tx_tmr_q + 1'b1;
      end
    end
  end

  // receive: synchronize, detect start edge, sample mid-bit; a start bit gone high is treated as a glitch
  always_ff @(posedge clk) begin
    if (!resetb) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_prev_q <= 1'b1;
      rx_busy_q <= 1'b0;
      rx_bit_q <= '0;
      rx_tmr_q <= '0;
      rx_sh_q <= '0;
    end else begin
      rx_s1_q <= uart_rx_i;
      rx_s2_q <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      if (!rx_busy_q) begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_busy_q <= 1'b1;
          rx_bit_q <= '0;
          rx_tmr_q <= '0;
        end
      end else if (rx_smp) begin
        rx_tmr_q <= '0;
        rx_bit_q <= rx_bit_q + 4'd1;
        if ((rx_bit_q == 4'd0 && rx_s2_q) || rx_bit_q == 4'd9) rx_busy_q <= 1'b0;
        if (rx_bit_q != 4'd0 && rx_bit_q != 4'd9) rx_sh_q <= {rx_s2_q, rx_sh_q[7:1]};
      end else begin
        rx_tmr_q <= rx_tmr_q + 1'b1;
      end
    end
  end

  // command sequencer next state
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    addr_d = addr_q;
    len_d = len_q;
    cnt_d = cnt_q;
    sent_d = sent_q;
    tmo_d = tmo_q;
    done_d = 1'b0;
    err_d = 1'b0;
    load = 1'b0;
    load_byte = 8'h00;
    case (state_q)
      IDLE: if (cmd_valid_i) begin
        op_d = cmd_op_i;
        addr_d = cmd_addr_i;
        len_d = cmd_op_i[1] ? cmd_len_i : 8'd1;
        cnt_d = 8'd0;
        sent_d = 1'b0;
        load = 1'b1;
        load_byte = op_byte;
        state_d = SEND_CMD;
      end
      SEND_CMD: if (tx_last) begin
        load = 1'b1;
        load_byte = addr_q;
        state_d = SEND_ADDR;
      end
      SEND_ADDR: if (tx_last) begin
        load = op_q[1];
        load_byte = len_q;
        tmo_d = '0;
        state_d = op_q[1] ? SEND_LEN : (op_q[0] ? RECV : SEND_DATA);
      end
      SEND_LEN: if (tx_last) begin
        tmo_d = '0;
        state_d = op_q[0] ? RECV : SEND_DATA;
      end
      SEND_DATA: if (sent_q && tx_last) begin
        done_d = 1'b1;
        state_d = IDLE;
      end
      RECV: begin
        tmo_d = tmo_q + 1'b1;
        if (rd_valid_o) begin
          tmo_d = '0;
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == len_q - 8'd1) begin
            done_d = 1'b1;
            state_d = IDLE;
          end
        end else if (rx_ferr || tmo_q == TMO_END) begin
          done_d = 1'b1;
          err_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (wr_hs) begin
      load = 1'b1;
      load_byte = wr_data_i;
      cnt_d = cnt_q + 8'd1;
      sent_d = cnt_q == len_q - 8'd1;
    end
  end

  // command sequencer state register
  always_ff @(posedge clk) begin
    if (!resetb) begin
      state_q <= IDLE;
      op_q <= '0;
      addr_q <= '0;
      len_q <= '0;
      cnt_q <= '0;
      sent_q <= 1'b0;
      tmo_q <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      addr_q <= addr_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
      sent_q <= sent_d;
      tmo_q <= tmo_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_uart_reg_master.sv
// tb_uart_reg_master: directed test of uart_reg_master with a UART slave model on uart_rx
module tb_uart_reg_master;
  logic clk = 1'b0;
  logic resetb = 1'b0;
  logic cmd_valid = 1'b0, cmd_ready;
  logic [1:0] cmd_op = '0;
  logic [7:0] cmd_addr = '0, cmd_len = '0, wr_data = '0, rd_data;
  logic wr_valid = 1'b0, wr_ready, rd_valid, busy, done, err, uart_tx;
  logic uart_rx = 1'b1;

  int errors = 0, checks = 0;
  int cyc = 0, acc = 0;
  int done_cnt = 0, done_cyc = 0, rd_cyc = 0, wr_cyc = 0, wr_cnt = 0;
  logic done_err = 1'b0;
  logic [8:0] tx_q[$];
  logic [7:0] rd_q[$];

  uart_reg_master #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .RX_TIMEOUT(64)) dut (
    .clk(clk), .resetb(resetb), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_op_i(cmd_op), .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len), .wr_data_i(wr_data),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .rd_data_o(rd_data), .rd_valid_o(rd_valid),
    .busy_o(busy), .done_o(done), .err_o(err), .uart_tx_o(uart_tx), .uart_rx_i(uart_rx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (done) begin done_cnt++; done_cyc = cyc; done_err = err; end
    if (rd_valid) begin rd_q.push_back(rd_data); rd_cyc = cyc; end
    if (wr_valid && wr_ready) begin wr_cnt++; wr_cyc = cyc + 1; end
  end

  // line decoder for uart_tx: stores {stop, data}
  initial begin
    logic [7:0] b;
    logic s;
    forever begin
      @(negedge uart_tx);
      repeat (5) @(negedge clk);
      for (int i = 0; i < 8; i++) begin repeat (10) @(negedge clk); b[i] = uart_tx; end
      repeat (10) @(negedge clk);
      s = uart_tx;
      tx_q.push_back({s, b});
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] l);
    int t = 0;
    @(negedge clk);
    cmd_op = op; cmd_addr = a; cmd_len = l; cmd_valid = 1'b1;
    while (!cmd_ready && t < 1000) begin @(negedge clk); t++; end
    acc = cyc + 1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic feed(input int n, input int gap, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      int t = 0;
      repeat (gap) @(negedge clk);
      wr_data = base + 8'(i);
      wr_valid = 1'b1;
      while (!wr_ready && t < 40000) begin @(negedge clk); t++; end
      if (t >= 40000) chk("wr_ready_timeout", 0, 1);
      @(negedge clk);
      wr_valid = 1'b0;
    end
  endtask

  task automatic rx_byte(input logic [7:0] b, input logic stop);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 8; i++) begin uart_rx = b[i]; repeat (10) @(negedge clk); end
    uart_rx = stop;
    repeat (10) @(negedge clk);
    uart_rx = 1'b1;
  endtask

  task automatic wait_tx(input int n);
    int t = 0;
    while (tx_q.size() < n && t < 40000) begin @(negedge clk); t++; end
    if (t >= 40000) chk("tx_bytes_timeout", tx_q.size(), n);
  endtask

  task automatic wait_done(input int base);
    int t = 0;
    while (done_cnt == base && t < 40000) begin @(negedge clk); t++; end
    @(negedge clk);
    chk("done_count", done_cnt - base, 1);
  endtask

  initial begin
    int db, tb, rb, wb, bad;
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_uart_tx", uart_tx, 1);
    resetb = 1'b1;
    @(negedge clk);
    chk("rst_idle", {cmd_ready, busy, wr_ready, rd_valid, done, err, uart_tx}, 7'b1000001);
    chk("rst_rd_data", rd_data, 8'h00);

    // single write: 3 gapless bytes, done 300 clocks after acceptance
    db = done_cnt; tb = tx_q.size();
    fork issue(2'b00, 8'h12, 8'h00); feed(1, 0, 8'hA5); join
    chk("w_ready_busy", {cmd_ready, busy}, 2'b01);
    wait_done(db);
    wait_tx(tb + 3);
    chk("w_b0", tx_q[tb], 9'h157);
    chk("w_b1", tx_q[tb+1], 9'h112);
    chk("w_b2", tx_q[tb+2], 9'h1A5);
    chk("w_done_time", done_cyc - acc, 300);
    chk("w_err", done_err, 0);

    // single read, slave replies 0x5C after the address byte
    db = done_cnt; tb = tx_q.size(); rb = rd_q.size();
    fork
      issue(2'b01, 8'h34, 8'h00);
      begin wait_tx(tb + 2); repeat (10) @(negedge clk); rx_byte(8'h5C, 1'b1); end
    join
    wait_done(db);
    chk("r_b0", tx_q[tb], 9'h152);
    chk("r_b1", tx_q[tb+1], 9'h134);
    chk("r_rd_cnt", rd_q.size() - rb, 1);
    chk("r_rd_data", rd_q[rb], 8'h5C);
    chk("r_done_after_rd", done_cyc - rd_cyc, 1);
    chk("r_err", done_err, 0);

    // block read of 4
    db = done_cnt; tb = tx_q.size(); rb = rd_q.size();
    fork
      issue(2'b11, 8'h10, 8'h04);
      begin
        wait_tx(tb + 3); repeat (10) @(negedge clk);
        for (int i = 0; i < 4; i++) rx_byte(8'h11 * 8'(i), 1'b1);
      end
    join
    wait_done(db);
    chk("br_hdr", {tx_q[tb], tx_q[tb+1], tx_q[tb+2]}, {9'h162, 9'h110, 9'h104});
    chk("br_rd_cnt", rd_q.size() - rb, 4);
    chk("br_rd_data", {rd_q[rb], rd_q[rb+1], rd_q[rb+2], rd_q[rb+3]}, 32'h00112233);
    chk("br_done_after_rd", done_cyc - rd_cyc, 1);
    chk("br_err", done_err, 0);

    // block write of 3 with 200-clock stalls between data bytes
    db = done_cnt; tb = tx_q.size(); wb = wr_cnt;
    fork issue(2'b10, 8'h40, 8'h03); feed(3, 200, 8'hC0); join
    wait_done(db);
    wait_tx(tb + 6);
    chk("bw_hdr", {tx_q[tb], tx_q[tb+1], tx_q[tb+2]}, {9'h142, 9'h140, 9'h103});
    chk("bw_data", {tx_q[tb+3], tx_q[tb+4], tx_q[tb+5]}, {9'h1C0, 9'h1C1, 9'h1C2});
    chk("bw_wr_cnt", wr_cnt - wb, 3);
    chk("bw_done_time", done_cyc - wr_cyc, 100);

    // block write with len 0: 256 data bytes, all gapless
    db = done_cnt; tb = tx_q.size(); wb = wr_cnt;
    fork issue(2'b10, 8'h00, 8'h00); feed(256, 0, 8'h00); join
    wait_done(db);
    wait_tx(tb + 259);
    bad = 0;
    for (int i = 0; i < 256; i++) if (tx_q[tb+3+i] !== {1'b1, 8'(i)}) bad++;
    chk("bw256_len_byte", tx_q[tb+2], 9'h100);
    chk("bw256_bad_bytes", bad, 0);
    chk("bw256_wr_cnt", wr_cnt - wb, 256);
    chk("bw256_done_time", done_cyc - acc, 25900);

    // read with silent line: RECV starts 200 clocks after accept, timeout 640 later
    db = done_cnt; rb = rd_q.size();
    issue(2'b01, 8'h55, 8'h00);
    wait_done(db);
    chk("to_done_time", done_cyc - acc, 840);
    chk("to_err", done_err, 1);
    chk("to_rd_cnt", rd_q.size() - rb, 0);

    // framing error on the response byte ends the command early
    db = done_cnt; tb = tx_q.size(); rb = rd_q.size();
    fork
      issue(2'b01, 8'h56, 8'h00);
      begin wait_tx(tb + 2); repeat (10) @(negedge clk); rx_byte(8'hE7, 1'b0); end
    join
    wait_done(db);
    chk("fe_err", done_err, 1);
    chk("fe_rd_cnt", rd_q.size() - rb, 0);
    chk("fe_early", (done_cyc - acc) < 400, 1);

    // reset in the middle of the first data byte of a block write
    db = done_cnt;
    wr_data = 8'h77; wr_valid = 1'b1;
    issue(2'b10, 8'h20, 8'h08);
    repeat (350) @(negedge clk);
    resetb = 1'b0;
    @(negedge clk);
    chk("mid_rst_tx", uart_tx, 1);
    chk("mid_rst_busy", {busy, cmd_ready, wr_ready}, 3'b000);
    wr_valid = 1'b0;
    repeat (3) @(negedge clk);
    resetb = 1'b1;
    repeat (200) @(negedge clk);
    chk("mid_rst_no_done", done_cnt - db, 0);

    // normal command after reset
    db = done_cnt; tb = tx_q.size();
    fork issue(2'b00, 8'h99, 8'h00); feed(1, 0, 8'h3C); join
    wait_done(db);
    wait_tx(tb + 3);
    chk("post_rst_bytes", {tx_q[tb], tx_q[tb+1], tx_q[tb+2]}, {9'h157, 9'h199, 9'h13C});
    chk("post_rst_done_time", done_cyc - acc, 300);
    chk("post_rst_err", done_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
